// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the multi-port calculator. Holds the
//               command encodings, response codes and the queued request
//               entry (cmd, op1, op2). Operand fields are sized for the widest
//               supported DATA_W (64). Narrower builds zero-extend into them.
// Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

    localparam int C_MAX_DATA_W = 64;

    // Command nibble encodings
    localparam logic [3:0] c_cmd_nop = 4'd0;
    localparam logic [3:0] c_cmd_add = 4'd1;
    localparam logic [3:0] c_cmd_sub = 4'd2;
    localparam logic [3:0] c_cmd_rol = 4'd3;
    localparam logic [3:0] c_cmd_ror = 4'd4;
    localparam logic [3:0] c_cmd_shl = 4'd5;
    localparam logic [3:0] c_cmd_shr = 4'd6;

    // Response codes
    localparam logic [1:0] c_resp_none = 2'd0;
    localparam logic [1:0] c_resp_ok   = 2'd1;
    localparam logic [1:0] c_resp_err  = 2'd2;

    typedef struct packed {
        logic [3:0]              cmd;
        logic [C_MAX_DATA_W-1:0] op1;
        logic [C_MAX_DATA_W-1:0] op2;
    } calc_entry_t;

endpackage
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// ============================================================================
// Module      : calc_alu
// Description : Purely combinational operation unit.
//               add/sub are unsigned with overflow/underflow reported as an
//               error response; shifts are logical with the amount taken
//               from the low log2(DATA_W) bits of op2.
//               Optional macro CALC_ROTATE_EN enables rotate-left (cmd 3)
//               and rotate-right (cmd 4); without it those are invalid.
// Ports       : cmd  [3:0]        command nibble
//               op1  [DATA_W-1:0] first operand
//               op2  [DATA_W-1:0] second operand / shift amount
//               resp [1:0]        1 success, 2 overflow/underflow/invalid
//               data [DATA_W-1:0] result, forced to 0 unless resp is 1
// Revision    : 1.0  initial release
// ============================================================================
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [1:0]        resp,
    output logic [DATA_W-1:0] data
);

    localparam int c_sh_w = $clog2(DATA_W);

    logic [c_sh_w-1:0] w_amt;
    logic [DATA_W:0]   w_sum;

    assign w_amt = op2[c_sh_w-1:0];
    assign w_sum = {1'b0, op1} + {1'b0, op2};

    always_comb begin
        resp = c_resp_err;
        data = '0;
        case (cmd)
            c_cmd_add: begin
                if (!w_sum[DATA_W]) begin
                    resp = c_resp_ok;
                    data = w_sum[DATA_W-1:0];
                end
            end
            c_cmd_sub: begin
                if (op2 <= op1) begin
                    resp = c_resp_ok;
                    data = op1 - op2;
                end
            end
            c_cmd_shl: begin
                resp = c_resp_ok;
                data = op1 << w_amt;
            end
            c_cmd_shr: begin
                resp = c_resp_ok;
                data = op1 >> w_amt;
            end
`ifdef CALC_ROTATE_EN
            // A shift by DATA_W yields 0, so amount 0 degenerates cleanly.
            c_cmd_rol: begin
                resp = c_resp_ok;
                data = (op1 << w_amt) | (op1 >> (DATA_W - w_amt));
            end
            c_cmd_ror: begin
                resp = c_resp_ok;
                data = (op1 >> w_amt) | (op1 << (DATA_W - w_amt));
            end
`endif
            default: begin
                resp = c_resp_err;
                data = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/calc_multiport.sv
`default_nettype none
// ============================================================================
// Module      : calc_multiport
// Description : Multi-requester calculator. Each port sends a two-cycle
//               request (cmd + op1, then op2), which is queued in a per-port
//               FIFO. A round-robin arbiter drains one FIFO entry per cycle
//               through calc_alu; the result is registered and shown on the
//               owning port's out_resp/out_data for exactly one cycle.
//               Optional macro CALC_ROTATE_EN (see calc_alu) adds rotates.
// Ports       : c_clk       clock, rising edge
//               reset       asynchronous active-low reset
//               req_cmd_in  [4*NUM_PORTS-1:0]      per-port command nibble
//               req_data_in [DATA_W*NUM_PORTS-1:0] per-port operand bus
//               req_ready   [NUM_PORTS-1:0]        port may issue a command
//               out_resp    [2*NUM_PORTS-1:0]      per-port response code
//               out_data    [DATA_W*NUM_PORTS-1:0] per-port result
// Revision    : 1.0  initial release
// ============================================================================
module calc_multiport
    import calc_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [2*NUM_PORTS-1:0]      out_resp,
    output logic [DATA_W*NUM_PORTS-1:0] out_data
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_port_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    // Held low through reset and for the first edge after release so that
    // req_ready reads 0 while reset is asserted.
    logic                          r_ready_en;
    logic [c_port_w-1:0]           r_rr_ptr;
    logic [2*NUM_PORTS-1:0]        r_out_resp;
    logic [DATA_W*NUM_PORTS-1:0]   r_out_data;

    logic [NUM_PORTS-1:0]          w_non_empty;
    logic [NUM_PORTS-1:0]          w_grant;
    logic                          w_grant_vld;
    logic [c_port_w-1:0]           w_grant_idx;
    calc_entry_t                   w_head [NUM_PORTS];
    calc_entry_t                   w_sel;
    logic [1:0]                    w_alu_resp;
    logic [DATA_W-1:0]             w_alu_data;
    logic                          w_unused_sel;

    // ------------------------------------------------------------------
    // Per-port request capture and command FIFO
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        calc_entry_t          r_mem [FIFO_DEPTH];
        logic [c_ptr_w-1:0]   r_wr_ptr;
        logic [c_ptr_w-1:0]   r_rd_ptr;
        logic [c_cnt_w-1:0]   r_count;
        logic                 r_half;
        logic [3:0]           r_half_cmd;
        logic [DATA_W-1:0]    r_half_op1;
        logic [3:0]           w_cmd;
        logic [DATA_W-1:0]    w_data;
        logic [c_cnt_w-1:0]   w_fill;
        logic                 w_accept;
        logic                 w_push;
        logic                 w_pop;

        assign w_cmd  = req_cmd_in[4*gi +: 4];
        assign w_data = req_data_in[DATA_W*gi +: DATA_W];

        // Counting the half-received request guarantees its operand2 cycle
        // always finds a free slot.
        assign w_fill         = r_count + c_cnt_w'(r_half);
        assign req_ready[gi]  = r_ready_en && (w_fill < c_depth);

        // While a request is half-received the nibble is operand2 data.
        assign w_accept = req_ready[gi] && !r_half && (w_cmd != c_cmd_nop);
        assign w_push   = r_half;
        assign w_pop    = w_grant[gi];

        assign w_non_empty[gi] = (r_count != '0);
        assign w_head[gi]      = r_mem[r_rd_ptr];

        always_ff @(posedge c_clk or negedge reset) begin
            if (!reset) begin
                r_half     <= 1'b0;
                r_half_cmd <= '0;
                r_half_op1 <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_accept) begin
                    r_half     <= 1'b1;
                    r_half_cmd <= w_cmd;
                    r_half_op1 <= w_data;
                end else if (r_half) begin
                    r_half <= 1'b0;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_cnt_w'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_cnt_w'(1);
                end
            end
        end

        // Storage needs no reset: the flushed pointers make old entries dead.
        always_ff @(posedge c_clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr].cmd <= r_half_cmd;
                r_mem[r_wr_ptr].op1 <= C_MAX_DATA_W'(r_half_op1);
                r_mem[r_wr_ptr].op2 <= C_MAX_DATA_W'(w_data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: search starts at r_rr_ptr (port after last grant)
    // ------------------------------------------------------------------
    always_comb begin
        int w_idx;
        w_idx       = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end
            if (!w_grant_vld && w_non_empty[c_port_w'(w_idx)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = c_port_w'(w_idx);
            end
        end
    end

    assign w_grant = w_grant_vld ? (NUM_PORTS'(1) << w_grant_idx) : '0;

    assign w_sel        = w_head[w_grant_idx];
    // Operand bits above DATA_W are always zero in narrow builds.
    assign w_unused_sel = ^w_sel;

    calc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .cmd  (w_sel.cmd),
        .op1  (w_sel.op1[DATA_W-1:0]),
        .op2  (w_sel.op2[DATA_W-1:0]),
        .resp (w_alu_resp),
        .data (w_alu_data)
    );

    // ------------------------------------------------------------------
    // Result register: one-cycle pulse on the granted port's lanes
    // ------------------------------------------------------------------
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_ready_en <= 1'b0;
            r_rr_ptr   <= '0;
            r_out_resp <= '0;
            r_out_data <= '0;
        end else begin
            r_ready_en <= 1'b1;
            r_out_resp <= '0;
            r_out_data <= '0;
            if (w_grant_vld) begin
                r_out_resp[2*w_grant_idx +: 2]           <= w_alu_resp;
                r_out_data[DATA_W*w_grant_idx +: DATA_W] <= w_alu_data;
                r_rr_ptr <= (w_grant_idx == c_port_w'(NUM_PORTS - 1))
                            ? '0 : w_grant_idx + c_port_w'(1);
            end
        end
    end

    assign out_resp = r_out_resp;
    assign out_data = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_calc_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_multiport
// Description : Scoreboard bench for calc_multiport (4 ports, 32-bit, depth 4).
//               Stimulus pushes expected {resp,data} per port; a negedge
//               monitor pops and compares whenever a port shows a response.
//               Honors CALC_ROTATE_EN for the rotate expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_calc_multiport;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int FD = 4;

    logic              c_clk = 1'b0;
    logic              reset;
    logic [4*NP-1:0]   req_cmd_in;
    logic [DW*NP-1:0]  req_data_in;
    logic [NP-1:0]     req_ready;
    logic [2*NP-1:0]   out_resp;
    logic [DW*NP-1:0]  out_data;

    int                checks = 0;
    int                errors = 0;
    int                cyc    = 0;
    logic [33:0]       exp_q [NP][$];
    int                order_q[$];
    int                stamp_q[$];

    calc_multiport #(
        .NUM_PORTS  (NP),
        .DATA_W     (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_ready   (req_ready),
        .out_resp    (out_resp),
        .out_data    (out_data)
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge c_clk) begin
        int          nresp;
        logic [1:0]  r;
        logic [31:0] d;
        logic [33:0] e;
        nresp = 0;
        for (int p = 0; p < NP; p++) begin
            r = out_resp[2*p +: 2];
            d = out_data[DW*p +: DW];
            checks++;
            if (r != 2'd0) begin
                nresp++;
                order_q.push_back(p);
                stamp_q.push_back(cyc);
                if (exp_q[p].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp port %0d: got resp %0d data %h, expected no response", p, r, d);
                end else begin
                    e = exp_q[p].pop_front();
                    if ({r, d} !== e) begin
                        errors++;
                        $display("FAIL resp_port%0d: got resp %0d data %h, expected resp %0d data %h",
                                 p, r, d, e[33:32], e[31:0]);
                    end
                end
            end else if (d !== 32'd0) begin
                errors++;
                $display("FAIL idle_data port %0d: got data %h with resp 0, expected 0", p, d);
            end
        end
        checks++;
        if (nresp > 1) begin
            errors++;
            $display("FAIL one_grant: got %0d responses in one cycle, expected at most 1", nresp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [3:0] cmd, input logic [31:0] d);
        req_cmd_in[4*p +: 4]   = cmd;
        req_data_in[DW*p +: DW] = d;
    endtask

    task automatic push_exp(input int p, input logic [1:0] r, input logic [31:0] d);
        exp_q[p].push_back({r, d});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Two-cycle request; op2_cmd is the nibble presented in the operand2 cycle.
    task automatic single(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [3:0] op2_cmd,
                          input logic [1:0] r, input logic [31:0] d);
        push_exp(p, r, d);
        drive(p, cmd, op1);
        tick();
        drive(p, op2_cmd, op2);
        tick();
        drive(p, 4'd0, 32'd0);
    endtask

    function automatic int pending();
        int n;
        n = 0;
        for (int p = 0; p < NP; p++) n += exp_q[p].size();
        return n;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (pending() != 0 && n < 60) begin
            tick();
            n++;
        end
        repeat (6) tick();
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (exp_q[p].size() != 0) begin
                errors++;
                $display("FAIL %s_drain port %0d: got %0d responses missing, expected 0", tag, p, exp_q[p].size());
                exp_q[p].delete();
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_cmd_in  = '0;
        req_data_in = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    function automatic logic [15:0] order_code();
        logic [15:0] c;
        c = 16'h0;
        for (int i = 0; i < order_q.size() && i < 4; i++) c = {c[11:0], 4'(order_q[i])};
        return c;
    endfunction

    task automatic batch();
        for (int p = 0; p < NP; p++) begin
            drive(p, 4'd1, 32'(p * 16 + 1));
            push_exp(p, 2'd1, 32'(p * 16 + 1 + p + 2));
        end
        tick();
        for (int p = 0; p < NP; p++) drive(p, 4'd0, 32'(p + 2));
        tick();
        req_cmd_in  = '0;
        req_data_in = '0;
    endtask

    task automatic check_batch(input string tag, input logic [15:0] exp_order);
        check({tag, "_count"}, 64'(order_q.size()), 64'd4);
        check({tag, "_order"}, 64'(order_code()), 64'(exp_order));
        if (stamp_q.size() == 4)
            check({tag, "_consecutive"}, 64'(stamp_q[3] - stamp_q[0]), 64'd3);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset       = 1'b0;
        req_cmd_in  = '0;
        req_data_in = '0;
        tick();
        @(negedge c_clk);
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_resp",  64'(out_resp),  64'h0);
        check("rst_data",  64'(out_data[63:0]), 64'h0);
        @(posedge c_clk);
        #1;
        reset = 1'b1;
        tick();
        check("ready_after_release", 64'(req_ready), 64'hF);

        // Port 0 add: response exactly 2 cycles after the operand2 cycle
        push_exp(0, 2'd1, 32'h8);
        drive(0, 4'd1, 32'h5);
        tick();
        drive(0, 4'd0, 32'h3);
        tick();
        drive(0, 4'd0, 32'h0);
        @(posedge c_clk);
        @(negedge c_clk);
        check("add_latency_resp", 64'(out_resp[1:0]), 64'd1);
        check("add_latency_data", 64'(out_data[31:0]), 64'h8);
        drain("add");

        // Arithmetic corner cases
        single(1, 4'd2, 32'd3,         32'd5,         4'd0, 2'd2, 32'd0);
        single(1, 4'd1, 32'hFFFF_FFFF, 32'd1,         4'd0, 2'd2, 32'd0);
        single(1, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 4'd0, 2'd1, 32'hFFFF_FFFF);
        single(1, 4'd2, 32'd10,        32'd3,         4'd0, 2'd1, 32'd7);
        single(1, 4'd2, 32'd7,         32'd7,         4'd0, 2'd1, 32'd0);
        single(2, 4'd5, 32'h1,         32'h24,        4'd0, 2'd1, 32'h10);
        single(2, 4'd6, 32'h8000_0000, 32'h3F,        4'd0, 2'd1, 32'h1);
        single(2, 4'd5, 32'h1,         32'd31,        4'd0, 2'd1, 32'h8000_0000);
        single(3, 4'd7, 32'h1234,      32'h1,         4'd0, 2'd2, 32'd0);
        single(3, 4'hF, 32'h1234,      32'h1,         4'd0, 2'd2, 32'd0);
        // Nonzero nibble in the operand2 cycle is just data
        single(3, 4'd1, 32'h10,        32'h20,        4'd2, 2'd1, 32'h30);
`ifdef CALC_ROTATE_EN
        single(0, 4'd3, 32'h8000_0001, 32'd1, 4'd0, 2'd1, 32'h0000_0003);
        single(0, 4'd4, 32'h0000_0003, 32'd1, 4'd0, 2'd1, 32'h8000_0001);
`else
        single(0, 4'd3, 32'h8000_0001, 32'd1, 4'd0, 2'd2, 32'd0);
        single(0, 4'd4, 32'h0000_0003, 32'd1, 4'd0, 2'd2, 32'd0);
`endif
        drain("alu");

        // Reset one cycle after an operand2 cycle, with port 3 half-received
        drive(0, 4'd1, 32'd1);
        tick();
        drive(0, 4'd0, 32'd2);
        drive(3, 4'd1, 32'd9);
        tick();
        reset = 1'b0;
        req_cmd_in  = '0;
        req_data_in = '0;
        @(negedge c_clk);
        check("midrst_resp",  64'(out_resp), 64'h0);
        check("midrst_ready", 64'(req_ready), 64'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_ready_release", 64'(req_ready), 64'hF);
        drain("flush");

        // Round-robin from port 0 after reset, repeat, then shifted start
        order_q.delete(); stamp_q.delete();
        batch();
        drain("batch1");
        check_batch("rr_batch1", 16'h0123);
        order_q.delete(); stamp_q.delete();
        batch();
        drain("batch2");
        check_batch("rr_batch2", 16'h0123);
        single(1, 4'd1, 32'd1, 32'd1, 4'd0, 2'd1, 32'd2);
        drain("rr_single");
        order_q.delete(); stamp_q.delete();
        batch();
        drain("batch3");
        check_batch("rr_batch3", 16'h2301);

        // Back-pressure on port 2 with all ports loading the arbiter
        do_reset();
        for (int c = 0; c < 14; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (p != 2) begin
                    if (c < 10 && c % 2 == 0) begin
                        drive(p, 4'd1, 32'(p * 100 + c));
                        push_exp(p, 2'd1, 32'(p * 100 + 2 * c + 1));
                    end else if (c < 10) begin
                        drive(p, 4'd0, 32'(c));
                    end else begin
                        drive(p, 4'd0, 32'd0);
                    end
                end
            end
            if (c <= 11 && c % 2 == 0) begin
                drive(2, 4'd1, 32'(200 + c));
                push_exp(2, 2'd1, 32'(200 + 2 * c + 1));
            end else if (c <= 11) begin
                drive(2, 4'd0, 32'(c));
            end else if (c == 12) begin
                drive(2, 4'd1, 32'h999);
            end else begin
                drive(2, 4'd0, 32'd0);
            end
            @(negedge c_clk);
            if (c == 10) check("bp_ready_c10", 64'(req_ready[2]), 64'd1);
            if (c == 11) check("bp_ready_c11", 64'(req_ready[2]), 64'd0);
            if (c == 12) check("bp_ready_c12", 64'(req_ready[2]), 64'd0);
            if (c == 13) check("bp_ready_c13", 64'(req_ready[2]), 64'd1);
            @(posedge c_clk);
            #1;
        end
        drain("backpressure");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
